// File: rtl/video_timing_generator.sv
// Raster timing source: walks an (h, v) pixel position once per clock and decodes
// the registered sync/visible/pulse bundle. Run/stop only takes effect on frame boundaries.
module video_timing_generator #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic                                                     clk_i,
  input  logic                                                     rst_n_i,
  input  logic                                                     enable_i,
  output logic                                                     end_of_frame_o,
  output logic                                                     end_of_visible_line_o,
  output logic                                                     hsync_n_o,
  output logic                                                     vsync_n_o,
  output logic                                                     visible_o,
  output logic [$clog2(H_VISIBLE+H_FRONT+H_SYNC+H_BACK)-1:0]       x_o,
  output logic [$clog2(V_VISIBLE+V_FRONT+V_SYNC+V_BACK)-1:0]       y_o,
  output logic                                                     running_o
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  logic [HW-1:0]   r_h;
  logic [VW-1:0]   r_v;
  logic            r_visible;
  logic            r_eovl;
  logic            r_eof;
  logic            r_hsync_n;
  logic            r_vsync_n;
  logic            r_running;
  logic [HW-1:0]   r_x;
  logic [VW-1:0]   r_y;

  logic            w_active;
  logic            w_h_last;
  logic            w_v_last;
  logic            w_frame_last;
  logic            w_h_vis;
  logic            w_v_vis;
  logic            w_h_sync;
  logic            w_v_sync;
  logic [HW-1:0]   w_h_next;
  logic [VW-1:0]   w_v_next;

  // Position decode from the current counters; registered below for one-cycle latency.
  assign w_active     = (r_state != ST_IDLE);
  assign w_h_last     = (r_h == HW'(H_TOTAL - 1));
  assign w_v_last     = (r_v == VW'(V_TOTAL - 1));
  assign w_frame_last = w_h_last && w_v_last;
  assign w_h_vis      = (r_h < HW'(H_VISIBLE));
  assign w_v_vis      = (r_v < VW'(V_VISIBLE));
  assign w_h_sync     = (r_h >= HW'(HS_START)) && (r_h < HW'(HS_END));
  assign w_v_sync     = (r_v >= VW'(VS_START)) && (r_v < VW'(VS_END));
  assign w_h_next     = w_h_last ? '0 : r_h + HW'(1);
  assign w_v_next     = !w_h_last ? r_v : (w_v_last ? '0 : r_v + VW'(1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= ST_IDLE;
      r_h       <= '0;
      r_v       <= '0;
      r_visible <= 1'b0;
      r_eovl    <= 1'b0;
      r_eof     <= 1'b0;
      r_hsync_n <= 1'b1;
      r_vsync_n <= 1'b1;
      r_running <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
    end else begin
      r_visible <= w_active && w_h_vis && w_v_vis;
      r_eovl    <= w_active && (r_h == HW'(H_VISIBLE)) && w_v_vis;
      r_eof     <= w_active && w_frame_last;
      r_hsync_n <= !(w_active && w_h_sync);
      r_vsync_n <= !(w_active && w_v_sync);
      r_running <= w_active;
      r_x       <= w_active ? r_h : '0;
      r_y       <= w_active ? r_v : '0;

      // Counters sit at (0,0) in IDLE; the frame-last wrap returns them there on stop.
      if (w_active) begin
        r_h <= w_h_next;
        r_v <= w_v_next;
      end

      case (r_state)
        ST_IDLE: begin
          if (enable_i) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (!enable_i) r_state <= w_frame_last ? ST_IDLE : ST_DRAIN;
        end
        ST_DRAIN: begin
          if (enable_i)          r_state <= ST_RUN;
          else if (w_frame_last) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign visible_o             = r_visible;
  assign end_of_visible_line_o = r_eovl;
  assign end_of_frame_o        = r_eof;
  assign hsync_n_o             = r_hsync_n;
  assign vsync_n_o             = r_vsync_n;
  assign running_o             = r_running;
  assign x_o                   = r_x;
  assign y_o                   = r_y;

endmodule

// File: tb/tb_video_timing_generator.sv
// Scoreboard bench for video_timing_generator: default 640x480 timing and a tiny 7x5 raster.
// Expected output transitions are queued with their cycle stamps; monitors pop on every change.
module tb_video_timing_generator;

  localparam int S_RUN  = 0;
  localparam int S_VIS  = 1;
  localparam int S_EOVL = 2;
  localparam int S_HS   = 3;
  localparam int S_VS   = 4;
  localparam int S_EOF  = 5;

  typedef struct {
    int     sig;
    bit     val;
    int     x;
    int     y;
    longint t;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // default-parameter instance
  logic       rst_d, en_d;
  logic       eof_d, eovl_d, hs_d, vs_d, vis_d, run_d;
  logic [9:0] x_d, y_d;

  // small-parameter instance: H 4/1/1/1 (7), V 2/1/1/1 (5)
  logic       rst_s, en_s;
  logic       eof_s, eovl_s, hs_s, vs_s, vis_s, run_s;
  logic [2:0] x_s, y_s;

  video_timing_generator dut_d (
    .clk_i(clk), .rst_n_i(rst_d), .enable_i(en_d),
    .end_of_frame_o(eof_d), .end_of_visible_line_o(eovl_d),
    .hsync_n_o(hs_d), .vsync_n_o(vs_d), .visible_o(vis_d),
    .x_o(x_d), .y_o(y_d), .running_o(run_d)
  );

  video_timing_generator #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dut_s (
    .clk_i(clk), .rst_n_i(rst_s), .enable_i(en_s),
    .end_of_frame_o(eof_s), .end_of_visible_line_o(eovl_s),
    .hsync_n_o(hs_s), .vsync_n_o(vs_s), .visible_o(vis_s),
    .x_o(x_s), .y_o(y_s), .running_o(run_s)
  );

  int n_chk  = 0;
  int n_pass = 0;
  ev_t q_d[$];
  ev_t q_s[$];
  bit mon_en_d = 1'b0;
  bit mon_en_s = 1'b0;
  logic [5:0] prev_d, prev_s;
  string sig_name[6] = '{"running", "visible", "eovl", "hsync_n", "vsync_n", "eof"};

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic push(input int inst, input int sig, input bit val, input int x, input int y,
                      input longint t);
    ev_t e;
    e.sig = sig; e.val = val; e.x = x; e.y = y; e.t = t;
    if (inst == 0) q_d.push_back(e);
    else q_s.push_back(e);
  endtask

  // Compare every output edge against the next queued expectation.
  task automatic observe(input int inst, input logic [5:0] prv, input logic [5:0] cur,
                         input int x, input int y);
    ev_t e;
    for (int i = 0; i < 6; i++) begin
      if (cur[i] !== prv[i]) begin
        n_chk++;
        if ((inst == 0 && q_d.size() == 0) || (inst == 1 && q_s.size() == 0)) begin
          $display("FAIL inst%0d unexpected %s->%b at x=%0d y=%0d t=%0d",
                   inst, sig_name[i], cur[i], x, y, cyc);
        end else begin
          e = (inst == 0) ? q_d.pop_front() : q_s.pop_front();
          if (e.sig == i && e.val == cur[i] && e.x == x && e.y == y && e.t == cyc)
            n_pass++;
          else
            $display("FAIL inst%0d edge: got %s->%b x=%0d y=%0d t=%0d, expected %s->%b x=%0d y=%0d t=%0d",
                     inst, sig_name[i], cur[i], x, y, cyc,
                     sig_name[e.sig], e.val, e.x, e.y, e.t);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en_d) observe(0, prev_d, {eof_d, vs_d, hs_d, eovl_d, vis_d, run_d}, int'(x_d), int'(y_d));
    prev_d <= {eof_d, vs_d, hs_d, eovl_d, vis_d, run_d};
  end

  always @(negedge clk) begin
    if (mon_en_s) observe(1, prev_s, {eof_s, vs_s, hs_s, eovl_s, vis_s, run_s}, int'(x_s), int'(y_s));
    prev_s <= {eof_s, vs_s, hs_s, eovl_s, vis_s, run_s};
  end

  // Hand-derived transition list for one 7x5 frame whose (0,0) output appears at stamp b.
  task automatic push_s_frame(input longint b, input bit from_idle);
    for (int y = 0; y < 5; y++) begin
      longint l = b + 7 * y;
      if (y == 0 && from_idle) push(1, S_RUN, 1'b1, 0, 0, l);
      if (y < 2) push(1, S_VIS, 1'b1, 0, y, l);
      if (y == 0 && !from_idle) push(1, S_EOF, 1'b0, 0, 0, l);
      if (y == 3) push(1, S_VS, 1'b0, 0, 3, l);
      if (y == 4) push(1, S_VS, 1'b1, 0, 4, l);
      if (y < 2) begin
        push(1, S_VIS,  1'b0, 4, y, l + 4);
        push(1, S_EOVL, 1'b1, 4, y, l + 4);
        push(1, S_EOVL, 1'b0, 5, y, l + 5);
      end
      push(1, S_HS, 1'b0, 5, y, l + 5);
      push(1, S_HS, 1'b1, 6, y, l + 6);
      if (y == 4) push(1, S_EOF, 1'b1, 6, 4, l + 6);
    end
  endtask

  task automatic push_stop(input int inst, input longint t);
    push(inst, S_RUN, 1'b0, 0, 0, t);
    push(inst, S_EOF, 1'b0, 0, 0, t);
  endtask

  // One visible 800-clock line at default timing.
  task automatic push_d_line(input longint b, input int y, input bit from_idle);
    longint l = b + 800 * y;
    if (from_idle) push(0, S_RUN, 1'b1, 0, y, l);
    push(0, S_VIS,  1'b1, 0,   y, l);
    push(0, S_VIS,  1'b0, 640, y, l + 640);
    push(0, S_EOVL, 1'b1, 640, y, l + 640);
    push(0, S_EOVL, 1'b0, 641, y, l + 641);
    push(0, S_HS,   1'b0, 656, y, l + 656);
    push(0, S_HS,   1'b1, 752, y, l + 752);
  endtask

  task automatic wait_cyc(input longint t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint b, b2, bd, bd2;
    rst_d = 1'b0; rst_s = 1'b0; en_d = 1'b0; en_s = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_flags_d", {run_d, vis_d, eovl_d, hs_d, vs_d, eof_d}, 6'b000110);
    chk("reset_xy_d", {x_d, y_d}, 0);
    chk("reset_flags_s", {run_s, vis_s, eovl_s, hs_s, vs_s, eof_s}, 6'b000110);
    chk("reset_xy_s", {x_s, y_s}, 0);
    rst_d = 1'b1; rst_s = 1'b1;
    mon_en_d = 1'b1; mon_en_s = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_hold_s", {run_s, vis_s, hs_s, vs_s}, 4'b0011);

    // small: three back-to-back frames, enable dropped mid third frame
    @(negedge clk);
    en_s = 1'b1;
    b = cyc + 2;
    push_s_frame(b, 1'b1);
    push_s_frame(b + 35, 1'b0);
    push_s_frame(b + 70, 1'b0);
    push_stop(1, b + 105);
    wait_cyc(b + 79);
    en_s = 1'b0;
    wait_cyc(b + 110);
    chk("s_idle_flags", {run_s, vis_s, eovl_s, hs_s, vs_s, eof_s}, 6'b000110);
    chk("s_idle_xy", {x_s, y_s}, 0);

    // small: drop at y=1, reassert at y=3, then a continuous frame that stops
    @(negedge clk);
    en_s = 1'b1;
    b2 = cyc + 2;
    push_s_frame(b2, 1'b1);
    push_s_frame(b2 + 35, 1'b0);
    push_stop(1, b2 + 70);
    wait_cyc(b2 + 8);
    en_s = 1'b0;
    wait_cyc(b2 + 23);
    en_s = 1'b1;
    wait_cyc(b2 + 43);
    en_s = 1'b0;
    wait_cyc(b2 + 75);
    chk("s_queue_empty", q_s.size(), 0);

    // default: 50 lines, then asynchronous reset at x=300 y=50
    @(negedge clk);
    en_d = 1'b1;
    bd = cyc + 2;
    for (int y = 0; y < 50; y++) push_d_line(bd, y, y == 0);
    push(0, S_VIS, 1'b1, 0, 50, bd + 50 * 800);
    wait_cyc(bd + 50 * 800 + 300);
    #2;
    chk("d_pre_reset_x", x_d, 300);
    chk("d_pre_reset_y", y_d, 50);
    chk("d_pre_reset_vis", vis_d, 1);
    mon_en_d = 1'b0;
    chk("d_queue_before_reset", q_d.size(), 0);
    rst_d = 1'b0;
    #1;
    chk("d_async_flags", {run_d, vis_d, eovl_d, hs_d, vs_d, eof_d}, 6'b000110);
    chk("d_async_xy", {x_d, y_d}, 0);
    repeat (3) @(negedge clk);
    rst_d = 1'b1;
    mon_en_d = 1'b1;
    bd2 = cyc + 2;
    push_d_line(bd2, 0, 1'b1);
    push_d_line(bd2, 1, 1'b0);
    wait_cyc(bd2 + 1599);
    #2;
    chk("d_restart_y", y_d, 1);
    chk("d_queue_empty", q_d.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
